ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit of the Tomasulo RISC-V core: holds the architectural fetch PC, issues one word request at a time to the instruction cache, predecodes each returned word into opType/op, and buffers it in an in-order instruction queue. The queue head feeds the decoder each cycle. JAL redirects fetch locally. ROB flushes restart fetch at the corrected PC.

## Interface
- IQ_DEPTH, 16: instruction-queue entries; power of two, at least 2.
- IQ_IDX_W, 4: log2(IQ_DEPTH).
- RESET_PC, 32'h0: fetch PC after reset.
- clk_in  input  1  core clock; all state updates on the rising edge.
- rst_in  input  1  reset; asynchronous, active-low.
- rdy_in  input  1  global enable; when low, all state holds.
- if_to_ic_valid  output  1  fetch request to the icache.
- if_to_ic_addr  output  32  request address, word-aligned.
- ic_to_if_ready  input  1  one-cycle pulse: returned word is valid.
- ic_to_if_inst  input  32  returned instruction word.
- dc_stall  input  1  downstream cannot accept this cycle (ROB, RS or LSB full).
- rob_to_if_flush  input  1  misprediction or exception redirect.
- rob_to_if_target_pc  input  32  restart PC, valid with flush.
- if_to_dc_ready  output  1  the head entry is presented and is consumed this cycle.
- if_to_dc_PC, if_to_dc_inst  output  32 each  PC and raw word of the head entry.
- if_to_dc_opType  output  `OP_TYPE  predecoded class of the head entry.
- if_to_dc_op  output  `OPENUM_TYPE  predecoded operation of the head entry.

## Operation
- **State.**
  - fetch_pc.
  - FSM with two states: IDLE and WAIT.
  - drop flag.
  - Circular queue with head, tail and count (IQ_IDX_W+1 bits). Entries hold {PC, inst, opType, op}.
- **IDLE.**
  - if_to_ic_valid = 1 when count < IQ_DEPTH and no flush this cycle.
  - if_to_ic_addr = fetch_pc.
  - A request goes to WAIT at the next edge.
- **WAIT.**
  - if_to_ic_valid = 0.
  - On ic_to_if_ready with drop = 0:
    - predecode and push {fetch_pc, inst, opType, op};
    - fetch_pc <= fetch_pc + imm_J if opcode = JAL, else fetch_pc + 4 (32-bit wrap);
    - go to IDLE.
  - On ic_to_if_ready with drop = 1: discard the word, clear drop, go to IDLE. fetch_pc keeps the flush target.
- **Predecode of opType** (opcode[6:0]):
  - 0110111 LUI; 0010111 AUIPC; 1101111 JAL; 1100111 JALR;
  - 1100011 BR; 0000011 LD; 0100011 ST; 0010011 RI; 0110011 RC.
- **Predecode of op:** from funct3, plus funct7[5] for RC and for RI shifts, using the shared op enum.
- **Illegal opcode:** enqueued as RI/ADDI with inst replaced by 32'h00000013 (NOP).
- **Output to the decoder.**
  - if_to_dc_ready = rdy_in & rst_in & (count != 0) & !dc_stall & !rob_to_if_flush.
  - Data outputs show the head entry combinationally; they are 0 when the queue is empty.
  - Pop on the edge ending any cycle in which if_to_dc_ready = 1.
- **Flush (highest priority).**
  - head, tail and count are cleared.
  - fetch_pc <= rob_to_if_target_pc.
  - Any push or pop in that cycle is suppressed.
  - If the FSM is in WAIT with no ic_to_if_ready that cycle: set drop and stay in WAIT.
  - If the FSM is in WAIT and ic_to_if_ready arrives that same cycle: the word is discarded and the FSM goes to IDLE.
- **rdy_in low:** no state changes; if_to_ic_valid = 0; if_to_dc_ready = 0. The icache honours rdy_in identically.

## Timing
- **Reset values:**
  - fetch_pc = RESET_PC; FSM = IDLE; drop = 0; head = tail = count = 0.
  - if_to_ic_valid = 0 while rst_in is low. if_to_dc_ready = 0. All data outputs = 0.
- **Latency:** request in cycle N, ic_to_if_ready in cycle M ≥ N+1. The entry is visible to the decoder in cycle M+1.
- **Throughput:** at most one request outstanding, so the sustained rate is one instruction per (icache latency + 1) cycles.
- **Simultaneous push and pop:** count unchanged; head and tail both advance, wrapping modulo IQ_DEPTH.
- **Full:** count = IQ_DEPTH blocks new requests. A response already in flight is always accepted: a request is only issued when count < IQ_DEPTH.
- **Empty:** if_to_dc_ready = 0. There is no bypass from icache to decoder.
- **Flush in cycle F:** the queue is empty in F+1. The first request to the target is in F+1 if the FSM is IDLE; otherwise it follows the dropped response. No stale word reaches the decoder after F.
- **Reset mid-WAIT:** the FSM returns to IDLE. The icache is reset by the same rst_in.

## Test plan
- **Reset then run, single-cycle icache:** words 0x00500093 and 0x00A00113 at 0x0 and 0x4 -> if_to_dc_PC 0x0 then 0x4; opType RI, op ADDI; one entry every 2 cycles.
- **JAL redirect:** 0x0080006F (jal x0,8) at PC 0x10 -> next request address 0x18; entry {PC 0x10, opType JAL} enqueued.
- **Full/stall:** dc_stall held high for 40 cycles -> count saturates at 16 with no lost or duplicated PCs. After release, 16 consecutive cycles with if_to_dc_ready = 1.
- **Flush while WAIT with 3-cycle icache latency:** flush to 0x100 in the cycle after the request -> the returning word is dropped; the next request is 0x100; the first decoder entry has PC 0x100.
- **Flush colliding with ic_to_if_ready and a pop:** queue empty next cycle; no entry pushed; fetch_pc = target.
- **rdy_in low for 5 cycles mid-stream:** all outputs and registers frozen. The sequence resumes identically when rdy_in returns high.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding icache request, predecode, and an in-order
// instruction queue feeding the decoder. JAL redirects locally, ROB flush restarts.
package ifetch_pkg;
  typedef enum logic [3:0] {
    OPT_NONE, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR, OPT_BR, OPT_LD, OPT_ST, OPT_RI, OPT_RC
  } op_type_e;

  typedef enum logic [5:0] {
    OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    op_type_e    op_type;
    op_e         op;
  } iq_entry_t;
endpackage

module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = 16,
  parameter int unsigned IQ_IDX_W = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_to_ic_valid,
  output logic [31:0] if_to_ic_addr,
  input  logic        ic_to_if_ready,
  input  logic [31:0] ic_to_if_inst,
  input  logic        dc_stall,
  input  logic        rob_to_if_flush,
  input  logic [31:0] rob_to_if_target_pc,
  output logic        if_to_dc_ready,
  output logic [31:0] if_to_dc_PC,
  output logic [31:0] if_to_dc_inst,
  output op_type_e    if_to_dc_opType,
  output op_e         if_to_dc_op
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [IQ_IDX_W:0]   FULL_CNT = (IQ_IDX_W+1)'(IQ_DEPTH);
  localparam logic [IQ_IDX_W-1:0] IDX_ONE  = IQ_IDX_W'(1);
  localparam logic [IQ_IDX_W:0]   CNT_ONE  = (IQ_IDX_W+1)'(1);
  localparam logic [31:0]         NOP_INST = 32'h0000_0013;

  state_e              state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic                drop_q, drop_d;
  logic [IQ_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IQ_IDX_W:0]   count_q, count_d;
  iq_entry_t           iq_q [IQ_DEPTH];

  logic        active, full, empty, resp, push, pop, legal, is_jal;
  logic [2:0]  f3;
  logic        f7b5;
  logic [31:0] imm_j;
  op_type_e    pd_type;
  op_e         pd_op;
  iq_entry_t   pd_entry, head_e;

  always_comb begin
    f3      = ic_to_if_inst[14:12];
    f7b5    = ic_to_if_inst[30];
    imm_j   = {{11{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[19:12],
               ic_to_if_inst[20], ic_to_if_inst[30:21], 1'b0};
    is_jal  = (ic_to_if_inst[6:0] == 7'b1101111);
    legal   = 1'b1;
    pd_type = OPT_NONE;
    pd_op   = OP_NONE;
    case (ic_to_if_inst[6:0])
      7'b0110111: begin pd_type = OPT_LUI;   pd_op = OP_LUI;   end
      7'b0010111: begin pd_type = OPT_AUIPC; pd_op = OP_AUIPC; end
      7'b1101111: begin pd_type = OPT_JAL;   pd_op = OP_JAL;   end
      7'b1100111: begin pd_type = OPT_JALR;  pd_op = OP_JALR;  legal = (f3 == 3'd0); end
      7'b1100011: begin
        pd_type = OPT_BR;
        case (f3)
          3'd0: pd_op = OP_BEQ;
          3'd1: pd_op = OP_BNE;
          3'd4: pd_op = OP_BLT;
          3'd5: pd_op = OP_BGE;
          3'd6: pd_op = OP_BLTU;
          3'd7: pd_op = OP_BGEU;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        pd_type = OPT_LD;
        case (f3)
          3'd0: pd_op = OP_LB;
          3'd1: pd_op = OP_LH;
          3'd2: pd_op = OP_LW;
          3'd4: pd_op = OP_LBU;
          3'd5: pd_op = OP_LHU;
          default: legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        pd_type = OPT_ST;
        case (f3)
          3'd0: pd_op = OP_SB;
          3'd1: pd_op = OP_SH;
          3'd2: pd_op = OP_SW;
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        pd_type = OPT_RI;
        case (f3)
          3'd0: pd_op = OP_ADDI;
          3'd1: pd_op = OP_SLLI;
          3'd2: pd_op = OP_SLTI;
          3'd3: pd_op = OP_SLTIU;
          3'd4: pd_op = OP_XORI;
          3'd5: pd_op = f7b5 ? OP_SRAI : OP_SRLI;
          3'd6: pd_op = OP_ORI;
          default: pd_op = OP_ANDI;
        endcase
      end
      7'b0110011: begin
        pd_type = OPT_RC;
        case (f3)
          3'd0: pd_op = f7b5 ? OP_SUB : OP_ADD;
          3'd1: pd_op = OP_SLL;
          3'd2: pd_op = OP_SLT;
          3'd3: pd_op = OP_SLTU;
          3'd4: pd_op = OP_XOR;
          3'd5: pd_op = f7b5 ? OP_SRA : OP_SRL;
          3'd6: pd_op = OP_OR;
          default: pd_op = OP_AND;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // Unknown encodings (bad opcode or reserved funct3) travel down the pipe as a NOP.
    pd_entry.pc      = fetch_pc_q;
    pd_entry.inst    = legal ? ic_to_if_inst : NOP_INST;
    pd_entry.op_type = legal ? pd_type : OPT_RI;
    pd_entry.op      = legal ? pd_op : OP_ADDI;
  end

  always_comb begin
    active         = rdy_in & rst_in;
    full           = (count_q == FULL_CNT);
    empty          = (count_q == '0);
    if_to_ic_valid = active & (state_q == S_IDLE) & ~full & ~rob_to_if_flush;
    if_to_ic_addr  = fetch_pc_q;
    if_to_dc_ready = active & ~empty & ~dc_stall & ~rob_to_if_flush;
    resp           = active & (state_q == S_WAIT) & ic_to_if_ready;
    push           = resp & ~drop_q & ~rob_to_if_flush;
    pop            = if_to_dc_ready;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (active) begin
      if (rob_to_if_flush) begin
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        fetch_pc_d = rob_to_if_target_pc;
        // An in-flight word must not be enqueued: drop it now or when it lands.
        if (state_q == S_WAIT) begin
          if (ic_to_if_ready) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
      end else begin
        unique case (state_q)
          S_IDLE: if (if_to_ic_valid) state_d = S_WAIT;
          S_WAIT: begin
            if (ic_to_if_ready) begin
              state_d = S_IDLE;
              if (drop_q) drop_d = 1'b0;
              else fetch_pc_d = fetch_pc_q + (is_jal ? imm_j : 32'd4);
            end
          end
        endcase
        if (push) tail_d = tail_q + IDX_ONE;
        if (pop)  head_d = head_q + IDX_ONE;
        if (push && !pop) count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset: outputs are masked to zero while empty.
  always_ff @(posedge clk_in) begin
    if (push) iq_q[tail_q] <= pd_entry;
  end

  always_comb begin
    head_e = iq_q[head_q];
    if (empty) begin
      if_to_dc_PC     = '0;
      if_to_dc_inst   = '0;
      if_to_dc_opType = OPT_NONE;
      if_to_dc_op     = OP_NONE;
    end else begin
      if_to_dc_PC     = head_e.pc;
      if_to_dc_inst   = head_e.inst;
      if_to_dc_opType = head_e.op_type;
      if_to_dc_op     = head_e.op;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: icache responder with configurable latency, scoreboard of
// expected decoder entries, and one task per scenario.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rdy_in, ic_to_if_ready, dc_stall, rob_to_if_flush;
  logic [31:0] ic_to_if_inst, rob_to_if_target_pc;
  logic        if_to_ic_valid, if_to_dc_ready;
  logic [31:0] if_to_ic_addr, if_to_dc_PC, if_to_dc_inst;
  op_type_e    if_to_dc_opType;
  op_e         if_to_dc_op;

  always #5 clk = ~clk;

  ifetch #(.IQ_DEPTH(16), .IQ_IDX_W(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy_in),
    .if_to_ic_valid(if_to_ic_valid), .if_to_ic_addr(if_to_ic_addr),
    .ic_to_if_ready(ic_to_if_ready), .ic_to_if_inst(ic_to_if_inst),
    .dc_stall(dc_stall), .rob_to_if_flush(rob_to_if_flush),
    .rob_to_if_target_pc(rob_to_if_target_pc),
    .if_to_dc_ready(if_to_dc_ready), .if_to_dc_PC(if_to_dc_PC),
    .if_to_dc_inst(if_to_dc_inst), .if_to_dc_opType(if_to_dc_opType),
    .if_to_dc_op(if_to_dc_op)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; op_type_e t; op_e op; } exp_t;
  typedef struct { int cyc; logic [31:0] pc; op_type_e t; } pop_t;
  typedef struct { int cyc; logic [31:0] addr; } req_t;

  int errors = 0, checks = 0, cyc = 0;
  exp_t sb[$];
  pop_t pop_log[$];
  req_t req_log[$];
  logic busy = 1'b0, drop_m = 1'b0;
  int wait_cnt = 0, lat = 1;
  logic [31:0] tb_pc = 32'h0, raddr = 32'h0;
  exp_t e;
  logic exp_ready, exp_valid;

  function automatic logic [31:0] prog(input logic [31:0] a);
    case (a)
      32'h00: return 32'h0050_0093;  // addi x1,x0,5
      32'h04: return 32'h00A0_0113;  // addi x2,x0,10
      32'h08: return 32'h4020_8233;  // sub x4,x1,x2
      32'h0C: return 32'hFFFF_FFFF;  // illegal
      32'h10: return 32'h0080_006F;  // jal x0,8
      32'h18: return 32'h0001_2083;  // lw x1,0(x2)
      32'h1C: return 32'h4030_D093;  // srai x1,x1,3
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic exp_t exp_entry(input logic [31:0] a);
    exp_t r;
    r.pc = a;
    case (a)
      32'h08:  begin r.inst = 32'h4020_8233; r.t = OPT_RC;  r.op = OP_SUB;  end
      32'h10:  begin r.inst = 32'h0080_006F; r.t = OPT_JAL; r.op = OP_JAL;  end
      32'h18:  begin r.inst = 32'h0001_2083; r.t = OPT_LD;  r.op = OP_LW;   end
      32'h1C:  begin r.inst = 32'h4030_D093; r.t = OPT_RI;  r.op = OP_SRAI; end
      32'h00:  begin r.inst = 32'h0050_0093; r.t = OPT_RI;  r.op = OP_ADDI; end
      32'h04:  begin r.inst = 32'h00A0_0113; r.t = OPT_RI;  r.op = OP_ADDI; end
      default: begin r.inst = 32'h0000_0013; r.t = OPT_RI;  r.op = OP_ADDI; end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return (a == 32'h10) ? 32'h18 : a + 32'd4;
  endfunction

  // Icache responder and decoder-side scoreboard; inputs drive at negedge, sample at +4.
  initial begin
    ic_to_if_ready = 1'b0;
    ic_to_if_inst  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      ic_to_if_ready = busy && (wait_cnt == 0);
      ic_to_if_inst  = ic_to_if_ready ? prog(raddr) : 32'hDEAD_BEEF;
      #4;
      if (!rst_n) begin
        busy = 1'b0; drop_m = 1'b0; tb_pc = 32'h0; sb.delete();
      end else if (!rdy_in) begin
        checks++;
        if (if_to_dc_ready !== 1'b0 || if_to_ic_valid !== 1'b0) begin
          errors++;
          $display("FAIL frozen_handshake cyc=%0d got dc_ready=%b ic_valid=%b exp 0/0",
                   cyc, if_to_dc_ready, if_to_ic_valid);
        end
      end else begin
        exp_ready = (sb.size() != 0) && !dc_stall && !rob_to_if_flush;
        exp_valid = !busy && (sb.size() < 16) && !rob_to_if_flush;
        checks++;
        if (if_to_dc_ready !== exp_ready) begin
          errors++;
          $display("FAIL dc_ready cyc=%0d got=%b exp=%b", cyc, if_to_dc_ready, exp_ready);
        end
        checks++;
        if (if_to_ic_valid !== exp_valid) begin
          errors++;
          $display("FAIL ic_valid cyc=%0d got=%b exp=%b", cyc, if_to_ic_valid, exp_valid);
        end
        if (if_to_dc_ready && sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          if (if_to_dc_PC !== e.pc || if_to_dc_inst !== e.inst ||
              if_to_dc_opType !== e.t || if_to_dc_op !== e.op) begin
            errors++;
            $display("FAIL dc_entry cyc=%0d got pc=%h inst=%h t=%0d op=%0d exp pc=%h inst=%h t=%0d op=%0d",
                     cyc, if_to_dc_PC, if_to_dc_inst, if_to_dc_opType, if_to_dc_op,
                     e.pc, e.inst, e.t, e.op);
          end
          pop_log.push_back('{cyc, if_to_dc_PC, if_to_dc_opType});
        end else if (sb.size() == 0) begin
          checks++;
          if ({if_to_dc_PC, if_to_dc_inst, if_to_dc_opType, if_to_dc_op} !== '0) begin
            errors++;
            $display("FAIL empty_outputs cyc=%0d got pc=%h inst=%h exp zeros", cyc, if_to_dc_PC, if_to_dc_inst);
          end
        end
        if (busy && ic_to_if_ready) begin
          if (!rob_to_if_flush && !drop_m) begin
            sb.push_back(exp_entry(tb_pc));
            tb_pc = next_pc(tb_pc);
          end
          drop_m = 1'b0;
          busy   = 1'b0;
        end else if (busy) begin
          if (rob_to_if_flush) drop_m = 1'b1;
          if (wait_cnt > 0) wait_cnt--;
        end
        if (rob_to_if_flush) begin
          sb.delete();
          tb_pc = rob_to_if_target_pc;
        end
        if (if_to_ic_valid) begin
          checks++;
          if (if_to_ic_addr !== tb_pc) begin
            errors++;
            $display("FAIL ic_addr cyc=%0d got=%h exp=%h", cyc, if_to_ic_addr, tb_pc);
          end
          req_log.push_back('{cyc, if_to_ic_addr});
          busy = 1'b1; raddr = if_to_ic_addr; wait_cnt = lat - 1;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; rdy_in = 1'b1; dc_stall = 1'b0;
    rob_to_if_flush = 1'b0; rob_to_if_target_pc = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (if_to_ic_valid !== 1'b0) begin errors++; $display("FAIL reset_ic_valid got=%b exp=0", if_to_ic_valid); end
    checks++;
    if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL reset_dc_ready got=%b exp=0", if_to_dc_ready); end
    checks++;
    if ({if_to_dc_PC, if_to_dc_inst, if_to_dc_opType, if_to_dc_op} !== '0) begin
      errors++; $display("FAIL reset_data got pc=%h inst=%h exp zeros", if_to_dc_PC, if_to_dc_inst);
    end
    checks++;
    if (if_to_ic_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", if_to_ic_addr); end
  endtask

  task automatic test_basic_run();
    int rel;
    pop_log.delete(); req_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #2 rel = cyc;
    for (int i = 0; i < 40 && pop_log.size() < 3; i++) @(negedge clk);
    checks++;
    if (pop_log.size() < 3) begin
      errors++; $display("FAIL basic_timeout got=%0d pops exp=3", pop_log.size());
    end else begin
      checks++;
      if (pop_log[0].pc !== 32'h0 || pop_log[1].pc !== 32'h4) begin
        errors++; $display("FAIL basic_pcs got=%h,%h exp=0,4", pop_log[0].pc, pop_log[1].pc);
      end
      checks++;
      if (pop_log[0].cyc - rel != 2) begin
        errors++; $display("FAIL basic_latency got=%0d exp=2", pop_log[0].cyc - rel);
      end
      checks++;
      if (pop_log[1].cyc - pop_log[0].cyc != 2 || pop_log[2].cyc - pop_log[1].cyc != 2) begin
        errors++; $display("FAIL basic_rate got=%0d,%0d exp=2,2",
                           pop_log[1].cyc - pop_log[0].cyc, pop_log[2].cyc - pop_log[1].cyc);
      end
    end
  endtask

  task automatic test_jal();
    int k = -1;
    for (int i = 0; i < 60 && k < 0; i++) begin
      @(negedge clk);
      foreach (pop_log[j]) if (pop_log[j].pc == 32'h10 && k < 0) k = j;
    end
    for (int i = 0; i < 10 && k >= 0 && pop_log.size() <= k + 1; i++) @(negedge clk);
    checks++;
    if (k < 0 || pop_log.size() <= k + 1) begin
      errors++; $display("FAIL jal_timeout got idx=%0d exp entry at 0x10 and successor", k);
    end else begin
      checks++;
      if (pop_log[k].t !== OPT_JAL) begin errors++; $display("FAIL jal_type got=%0d exp=%0d", pop_log[k].t, OPT_JAL); end
      checks++;
      if (pop_log[k+1].pc !== 32'h18) begin errors++; $display("FAIL jal_target got=%h exp=00000018", pop_log[k+1].pc); end
    end
    k = -1;
    foreach (req_log[j]) if (req_log[j].addr == 32'h10 && k < 0) k = j;
    checks++;
    if (k < 0 || req_log.size() <= k + 1 || req_log[k+1].addr !== 32'h18) begin
      errors++; $display("FAIL jal_request got idx=%0d exp request 0x18 after 0x10", k);
    end
  endtask

  task automatic test_full_stall();
    int run = 0;
    @(negedge clk) dc_stall = 1'b1;
    repeat (40) @(negedge clk);
    #2;
    checks++;
    if (dut.count_q !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", dut.count_q); end
    checks++;
    if (if_to_ic_valid !== 1'b0) begin errors++; $display("FAIL full_blocks_req got=%b exp=0", if_to_ic_valid); end
    @(negedge clk) dc_stall = 1'b0;
    #2;
    while (if_to_dc_ready === 1'b1 && run < 100) begin
      run++;
      @(negedge clk); #2;
    end
    checks++;
    if (run < 16) begin errors++; $display("FAIL full_drain got=%0d consecutive exp>=16", run); end
  endtask

  task automatic test_flush_wait();
    int n = -1, rq, pp;
    lat = 3;
    for (int i = 0; i < 20 && n < 0; i++) begin
      @(negedge clk); #2;
      if (if_to_ic_valid) n = cyc;
    end
    @(negedge clk);
    rob_to_if_flush = 1'b1; rob_to_if_target_pc = 32'h100;
    rq = req_log.size(); pp = pop_log.size();
    #2;
    checks++;
    if (n < 0 || if_to_ic_valid !== 1'b0) begin
      errors++; $display("FAIL flush_wait_req got valid=%b n=%0d exp 0", if_to_ic_valid, n);
    end
    @(negedge clk) rob_to_if_flush = 1'b0;
    #2;
    checks++;
    if (if_to_dc_ready !== 1'b0 || if_to_dc_PC !== 32'h0) begin
      errors++; $display("FAIL flush_wait_empty got ready=%b pc=%h exp 0/0", if_to_dc_ready, if_to_dc_PC);
    end
    for (int i = 0; i < 20 && req_log.size() <= rq; i++) @(negedge clk);
    checks++;
    if (req_log.size() <= rq || req_log[rq].addr !== 32'h100 || req_log[rq].cyc != n + 4) begin
      errors++; $display("FAIL flush_wait_next_req got n=%0d reqs=%0d exp 0x100 at cyc %0d", n, req_log.size() - rq, n + 4);
    end
    lat = 1;
    for (int i = 0; i < 30 && pop_log.size() <= pp; i++) @(negedge clk);
    checks++;
    if (pop_log.size() <= pp || pop_log[pp].pc !== 32'h100) begin
      errors++; $display("FAIL flush_wait_first_pc got pops=%0d exp first pc 00000100", pop_log.size() - pp);
    end
  endtask

  task automatic test_flush_collide();
    logic found = 1'b0;
    lat = 1;
    @(negedge clk) dc_stall = 1'b1;
    repeat (8) @(negedge clk);
    dc_stall = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      #2;
      if (ic_to_if_ready && if_to_dc_ready) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL collide_timeout got none exp ready+pop cycle");
    end else begin
      rob_to_if_flush = 1'b1; rob_to_if_target_pc = 32'h200;
      #1;
      checks++;
      if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL collide_pop_masked got=%b exp=0", if_to_dc_ready); end
      @(negedge clk) rob_to_if_flush = 1'b0;
      #2;
      checks++;
      if (if_to_dc_ready !== 1'b0 || if_to_dc_PC !== 32'h0) begin
        errors++; $display("FAIL collide_empty got ready=%b pc=%h exp 0/0", if_to_dc_ready, if_to_dc_PC);
      end
      checks++;
      if (if_to_ic_valid !== 1'b1 || if_to_ic_addr !== 32'h200) begin
        errors++; $display("FAIL collide_restart got valid=%b addr=%h exp 1/00000200", if_to_ic_valid, if_to_ic_addr);
      end
    end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] addr_c, pc_c, inst_c, fpc_c;
    logic [4:0]  cnt_c;
    @(negedge clk) dc_stall = 1'b1;
    repeat (6) @(negedge clk);
    dc_stall = 1'b0; rdy_in = 1'b0;
    #2;
    addr_c = if_to_ic_addr; pc_c = if_to_dc_PC; inst_c = if_to_dc_inst;
    fpc_c = dut.fetch_pc_q; cnt_c = dut.count_q;
    checks++;
    if (cnt_c == 5'd0) begin errors++; $display("FAIL freeze_setup got count=0 exp nonzero"); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      checks++;
      if (if_to_ic_addr !== addr_c || if_to_dc_PC !== pc_c || if_to_dc_inst !== inst_c ||
          dut.fetch_pc_q !== fpc_c || dut.count_q !== cnt_c) begin
        errors++; $display("FAIL freeze_hold got pc=%h cnt=%0d fpc=%h exp pc=%h cnt=%0d fpc=%h",
                           if_to_dc_PC, dut.count_q, dut.fetch_pc_q, pc_c, cnt_c, fpc_c);
      end
    end
    @(negedge clk) rdy_in = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    logic seen = 1'b0;
    lat = 3;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #2;
      if (if_to_ic_valid) seen = 1'b1;
    end
    @(negedge clk) rst_n = 1'b0;
    #2;
    checks++;
    if (!seen || if_to_ic_valid !== 1'b0 || if_to_dc_ready !== 1'b0 || if_to_dc_PC !== 32'h0) begin
      errors++; $display("FAIL midwait_reset got valid=%b ready=%b pc=%h exp 0/0/0",
                         if_to_ic_valid, if_to_dc_ready, if_to_dc_PC);
    end
    @(negedge clk) rst_n = 1'b1;
    lat = 1;
    #2;
    checks++;
    if (if_to_ic_valid !== 1'b1 || if_to_ic_addr !== 32'h0) begin
      errors++; $display("FAIL midwait_restart got valid=%b addr=%h exp 1/00000000", if_to_ic_valid, if_to_ic_addr);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_jal();
    test_full_stall();
    test_flush_wait();
    test_flush_collide();
    test_rdy_freeze();
    test_reset_mid_wait();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
